wb_sram_bridge: RTL
===================

// Module: wb_sram_bridge
//
// PURPOSE
//  Wishbone classic (B4, single-transfer) slave that fronts the 32x256 1RW1R
//  SRAM macro's RW port 0. Decodes a window of the Wishbone bus, registers all
//  SRAM control, address and data signals, and returns read data with a
//  fixed-latency single-cycle ack. Sits between the user-project Wishbone
//  interconnect and the SRAM macro. The SRAM clk0 is wb_clk_i.
//
// PARAMETERS
//  ADDR_WIDTH  8             SRAM word-address width (depth = 1<<ADDR_WIDTH)
//  DATA_WIDTH  32            data width; fixed at 32 (4 byte lanes)
//  NUM_WMASKS  4             byte-lane write-mask width
//  BASE_ADDR   32'h3000_0000 window base; bits [ADDR_WIDTH+1:0] ignored
//
// PORTS
//  wb_clk_i     in   1   system clock; also drives SRAM clk0
//  wb_rst_i     in   1   asynchronous, active-high reset
//  wbs_cyc_i    in   1   bus cycle valid
//  wbs_stb_i    in   1   strobe
//  wbs_we_i     in   1   1=write, 0=read
//  wbs_sel_i    in   4   byte selects
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   transfer ack, one-cycle pulse
//  wbs_err_o    out  1   bus error (see CONFIGURATION)
//  wbs_dat_o    out  32  read data, held until next read completes
//  sram_csb0    out  1   SRAM chip select, active low
//  sram_web0    out  1   SRAM write enable, active low
//  sram_wmask0  out  4   SRAM byte write mask
//  sram_addr0   out  8   SRAM word address = wbs_adr_i[ADDR_WIDTH+1:2]
//  sram_din0    out  32  SRAM write data
//  sram_dout0   in   32  SRAM read data (updates on clk0 falling edge)
//
// BEHAVIOUR
//  - Reset (async, any cycle): state=IDLE, sram_csb0=1, sram_web0=1,
//    sram_wmask0=0, sram_addr0=0, sram_din0=0, wbs_ack_o=0, wbs_err_o=0,
//    wbs_dat_o=0. An SRAM write already latched by the macro is not undone.
//  - hit = cyc & stb & (wbs_adr_i[31:ADDR_WIDTH+2]==BASE_ADDR[31:ADDR_WIDTH+2]).
//  - FSM: IDLE, ISSUE, READ, ACK (+ERR with macro). All outputs registered.
//  - IDLE: on hit at edge N -> ISSUE; register csb0=0, web0=~we, addr, din,
//    wmask = we ? sel : 4'b0.
//  - ISSUE (one cycle): SRAM samples at edge N+1; csb0/web0 return to 1.
//    Write -> ACK (ack=1 during N+1..N+2). Read -> READ.
//  - READ: dout0 valid after falling edge; at N+2 wbs_dat_o<=sram_dout0,
//    -> ACK (ack=1 during N+2..N+3).
//  - ACK: ack high exactly one cycle, then IDLE. Master drops stb at N+3;
//    next request accepted no earlier than the edge after ACK.
//  - Write latency 1 cycle, read latency 2 cycles, edge-to-ack.
//  - cyc low at the edge leaving ISSUE or READ: SRAM access still completes,
//    ack suppressed, -> IDLE; wbs_dat_o not updated.
//  - Write with sel=0: SRAM access issued with wmask0=0, acked normally.
//  - Non-hit request in IDLE without macro: ignored, no ack, no SRAM access.
//  - wbs_dat_o changes only on completed reads; writes leave it unchanged.
//  - Back-to-back: ack never asserted two consecutive cycles.
//
// CONFIGURATION
//  WB_SRAM_BRIDGE_ERR_EN defined: cyc&stb with address outside window in
//   IDLE -> ERR; wbs_err_o=1 for one cycle (N+1..N+2), no SRAM access, then
//   IDLE. ack and err never high together.
//  Undefined: wbs_err_o tied 0; ERR state not built; misses ignored.
//
// TESTING
//  1 Reset mid-ISSUE: assert wb_rst_i between edges -> outputs at reset
//    values immediately, state IDLE, no ack.
//  2 Write 0xDEADBEEF to 0x3000_0010 sel=4'hF, read back -> write ack 1
//    cycle after accept, read ack 2 cycles after accept, wbs_dat_o=0xDEADBEEF,
//    sram_addr0=8'h04.
//  3 Write 0x11223344 sel=4'b0101 over 0xFFFFFFFF at 0x3000_03FC -> readback
//    0xFF22FF44; address wraps to word 8'hFF.
//  4 cyc dropped during READ -> no ack, wbs_dat_o keeps previous value,
//    next read of same word acks normally.
//  5 Access 0x3000_0400 -> with macro: err pulse 1 cycle, csb0 stays 1;
//    without macro: no ack/err, csb0 stays 1.
//  6 Ten back-to-back alternating writes/reads, random addr/sel -> each ack
//    one cycle wide, data matches scoreboard.

Source files
------------

// File: rtl/wb_sram_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge_if
//
// Purpose: Wishbone classic (B4) slave-side signal bundle between the
// user-project interconnect and wb_sram_bridge. Signal names keep the
// _i/_o suffixes as seen from the slave.
//
// Signals:
//   wbs_cyc_i   1   bus cycle valid
//   wbs_stb_i   1   strobe
//   wbs_we_i    1   1=write, 0=read
//   wbs_sel_i   4   byte selects
//   wbs_adr_i   32  byte address
//   wbs_dat_i   32  write data
//   wbs_ack_o   1   transfer ack, one-cycle pulse
//   wbs_err_o   1   bus error
//   wbs_dat_o   32  read data
//
// Modports: master (interconnect side), slave (bridge side).
// ---------------------------------------------------------------------------
interface wb_sram_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge
//
// Purpose: Wishbone classic single-transfer slave in front of RW port 0 of a
// 32x256 1RW1R SRAM macro. Decodes an address window, registers every SRAM
// control/address/data signal, and returns a one-cycle ack: writes ack one
// cycle after acceptance, reads two cycles after acceptance.
//
// Ports:
//   wb_clk_i      in   1   system clock, also the SRAM clk0
//   wb_rst_i      in   1   asynchronous, active-high reset
//   wbs           slave modport of wb_sram_bridge_if (Wishbone signals)
//   sram_csb0     out  1   SRAM chip select, active low
//   sram_web0     out  1   SRAM write enable, active low
//   sram_wmask0   out  4   SRAM byte write mask
//   sram_addr0    out  8   SRAM word address
//   sram_din0     out  32  SRAM write data
//   sram_dout0    in   32  SRAM read data (valid after clk0 falling edge)
//
// Optional feature: define WB_SRAM_BRIDGE_ERR_EN to answer out-of-window
// requests with a one-cycle wbs_err_o pulse. Without it, misses are ignored
// and wbs_err_o is tied low.
// ---------------------------------------------------------------------------
module wb_sram_bridge #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_sram_bridge_if.slave       wbs,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

`ifdef WB_SRAM_BRIDGE_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_READ, S_ACK, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ, S_ACK} state_t;
`endif

  state_t                state_q, state_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
`ifdef WB_SRAM_BRIDGE_ERR_EN
  logic                  err_q, err_d;
`endif

  logic req;
  logic in_window;
  logic hit;

  // Byte-offset bits never reach the word-addressed SRAM.
  logic unused_adr_bits;
  assign unused_adr_bits = ^wbs.wbs_adr_i[1:0];

  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign in_window = (wbs.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign hit       = req & in_window;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
`ifdef WB_SRAM_BRIDGE_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
`ifdef WB_SRAM_BRIDGE_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    // Chip select and write enable are single-cycle strobes: idle high
    // unless the IDLE branch below launches an access.
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
`ifdef WB_SRAM_BRIDGE_ERR_EN
    err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_ISSUE;
          csb_d   = 1'b0;
          web_d   = ~wbs.wbs_we_i;
          addr_d  = wbs.wbs_adr_i[ADDR_WIDTH+1:2];
          din_d   = wbs.wbs_dat_i;
          wmask_d = wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
        end
`ifdef WB_SRAM_BRIDGE_ERR_EN
        else if (req) begin
          state_d = S_ERR;
        end
`endif
      end

      // SRAM samples the launched command on this edge. web_q still holds
      // the direction of that command, so no separate write flag is kept.
      // If the master has abandoned the cycle the access still lands in the
      // macro but no response is returned.
      S_ISSUE: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (!web_q) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end

      // Macro output settled on the preceding falling edge.
      S_READ: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = sram_dout0;
        end
      end

      // Response cycle (ack or err visible); always returns to IDLE so a
      // new request is never accepted while a response is on the bus.
      S_ACK: begin
        state_d = S_IDLE;
      end

`ifdef WB_SRAM_BRIDGE_ERR_EN
      // Mirrors ISSUE timing so err appears with write-ack latency.
      S_ERR: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sram_csb0     = csb_q;
  assign sram_web0     = web_q;
  assign sram_wmask0   = wmask_q;
  assign sram_addr0    = addr_q;
  assign sram_din0     = din_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
`ifdef WB_SRAM_BRIDGE_ERR_EN
  assign wbs.wbs_err_o = err_q;
`else
  assign wbs.wbs_err_o = 1'b0;
`endif

endmodule
